// File: rtl/ras_ckpt_ctrl_pkg.sv
// Shared sizes, FSM encoding and small helpers for the RAS checkpoint controller.
// The return stack and checkpoint queue modules import this package.
package ras_ckpt_ctrl_pkg;

  localparam int RAS_DEPTH  = 16;
  localparam int RAS_PTRW   = 4;
  localparam int CKPT_DEPTH = 16;
  localparam int CKPT_TAGW  = 4;
  localparam int CKPT_DATAW = 64;

  typedef enum logic {
    CK_IDLE   = 1'b0,
    CK_REPAIR = 1'b1
  } ckpt_state_e;

  // Queue is full when the index bits match and the wrap bits differ.
  function automatic logic ckpt_is_full(input logic [CKPT_TAGW:0] head,
                                        input logic [CKPT_TAGW:0] tail);
    return (head[CKPT_TAGW-1:0] == tail[CKPT_TAGW-1:0]) &&
           (head[CKPT_TAGW] != tail[CKPT_TAGW]);
  endfunction

endpackage

// File: rtl/ras_ckpt_mem.sv
// Checkpoint storage: one synchronous write port and one asynchronous read port.
// The stored data is not reset; head/tail validity decides which entries are live.
module ras_ckpt_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 68
) (
  input  logic          clock,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ras_ckpt_ctrl.sv
// Return-address-stack checkpoint controller: saves {ptr, TOS} per predicted branch,
// frees entries at retire, and replays the saved state into the RAS on a mispredict.
module ras_ckpt_ctrl
  import ras_ckpt_ctrl_pkg::*;
#(
  parameter int DEPTH = CKPT_DEPTH,
  parameter int TAGW  = CKPT_TAGW,
  parameter int PTRW  = RAS_PTRW,
  parameter int DATAW = CKPT_DATAW
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              alloc_vld_i,
  input  logic [PTRW-1:0]   alloc_ptr_i,
  input  logic [DATAW-1:0]  alloc_tos_i,
  output logic [TAGW-1:0]   alloc_tag_o,
  output logic              alloc_ack_o,
  output logic              full_o,
  input  logic              retire_vld_i,
  input  logic              mispredict_i,
  input  logic [TAGW-1:0]   mispredict_tag_i,
  output logic              repair_vld_o,
  output logic [PTRW-1:0]   repair_ptr_o,
  output logic              repair_we_o,
  output logic [DATAW-1:0]  repair_data_o,
  output logic              busy_o,
  output logic [TAGW:0]     count_o,
  output logic              err_o
);

  localparam int EW = PTRW + DATAW;

  logic [TAGW:0]      head_q, head_d;
  logic [TAGW:0]      tail_q, tail_d;
  logic               err_q, err_d;
  logic               repair_vld_q;
  logic [PTRW-1:0]    repair_ptr_q;
  logic [DATAW-1:0]   repair_data_q;
  ckpt_state_e        state_q;

  logic               empty;
  logic               full;
  logic [TAGW:0]      count;
  logic [TAGW-1:0]    mp_offset;
  logic               mp_valid;
  logic               ack;
  logic               retire_ok;
  logic [EW-1:0]      rd_entry;

  ras_ckpt_mem #(
    .DEPTH (DEPTH),
    .AW    (TAGW),
    .W     (EW)
  ) u_mem (
    .clock   (clock),
    .we_i    (ack),
    .waddr_i (tail_q[TAGW-1:0]),
    .wdata_i ({alloc_ptr_i, alloc_tos_i}),
    .raddr_i (mispredict_tag_i),
    .rdata_o (rd_entry)
  );

  assign empty = (head_q == tail_q);
  assign full  = ckpt_is_full(head_q, tail_q);
  assign count = tail_q - head_q;

  // A tag is live when its distance from head is below the live count.
  assign mp_offset = mispredict_tag_i - head_q[TAGW-1:0];
  assign mp_valid  = mispredict_i && !empty && ({1'b0, mp_offset} < count);

  assign ack = reset_n && alloc_vld_i && !full && (state_q == CK_IDLE) && !mispredict_i;

  // Retiring the very branch being squashed would double-free it.
  assign retire_ok = retire_vld_i && !empty && !(mp_valid && (mp_offset == '0));

  always_comb begin
    head_d = head_q + (TAGW+1)'(retire_ok);
    tail_d = tail_q + (TAGW+1)'(ack);
    if (mp_valid) begin
      tail_d = head_q + {1'b0, mp_offset};
    end
    err_d = err_q || (mispredict_i && !mp_valid);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q        <= '0;
      tail_q        <= '0;
      err_q         <= 1'b0;
      state_q       <= CK_IDLE;
      repair_vld_q  <= 1'b0;
      repair_ptr_q  <= '0;
      repair_data_q <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      err_q        <= err_d;
      repair_vld_q <= mp_valid;
      if (mp_valid) begin
        state_q       <= CK_REPAIR;
        repair_ptr_q  <= rd_entry[EW-1:DATAW];
        repair_data_q <= rd_entry[DATAW-1:0];
      end else begin
        state_q <= CK_IDLE;
      end
    end
  end

  assign alloc_tag_o   = tail_q[TAGW-1:0];
  assign alloc_ack_o   = ack;
  assign full_o        = full;
  assign count_o       = count;
  assign repair_vld_o  = repair_vld_q;
  assign repair_we_o   = repair_vld_q;
  assign repair_ptr_o  = repair_ptr_q;
  assign repair_data_o = repair_data_q;
  assign busy_o        = (state_q == CK_REPAIR);
  assign err_o         = err_q;

endmodule

// File: tb/tb_ras_ckpt_ctrl.sv
// Bench for ras_ckpt_ctrl: directed scenarios with a repair scoreboard.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_ras_ckpt_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        alloc_vld_i = 1'b0;
  logic [3:0]  alloc_ptr_i = '0;
  logic [63:0] alloc_tos_i = '0;
  logic [3:0]  alloc_tag_o;
  logic        alloc_ack_o;
  logic        full_o;
  logic        retire_vld_i = 1'b0;
  logic        mispredict_i = 1'b0;
  logic [3:0]  mispredict_tag_i = '0;
  logic        repair_vld_o;
  logic [3:0]  repair_ptr_o;
  logic        repair_we_o;
  logic [63:0] repair_data_o;
  logic        busy_o;
  logic [4:0]  count_o;
  logic        err_o;

  typedef struct {
    logic [3:0]  ptr;
    logic [63:0] data;
  } exp_repair_t;

  exp_repair_t sb_q[$];
  int total = 0;
  int bad   = 0;

  ras_ckpt_ctrl dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .alloc_vld_i      (alloc_vld_i),
    .alloc_ptr_i      (alloc_ptr_i),
    .alloc_tos_i      (alloc_tos_i),
    .alloc_tag_o      (alloc_tag_o),
    .alloc_ack_o      (alloc_ack_o),
    .full_o           (full_o),
    .retire_vld_i     (retire_vld_i),
    .mispredict_i     (mispredict_i),
    .mispredict_tag_i (mispredict_tag_i),
    .repair_vld_o     (repair_vld_o),
    .repair_ptr_o     (repair_ptr_o),
    .repair_we_o      (repair_we_o),
    .repair_data_o    (repair_data_o),
    .busy_o           (busy_o),
    .count_o          (count_o),
    .err_o            (err_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, obs, exp);
    end else begin
      $display("ok   %s: %0h", name, obs);
    end
  endtask

  // Every repair pulse must match the oldest outstanding expected repair.
  always @(negedge clock) begin
    if (reset_n && repair_vld_o) begin
      if (sb_q.size() == 0) begin
        check("repair_unexpected", 64'd1, 64'd0);
      end else begin
        exp_repair_t e;
        e = sb_q.pop_front();
        check("sb_repair_ptr", 64'(repair_ptr_o), 64'(e.ptr));
        check("sb_repair_data", repair_data_o, e.data);
        check("sb_repair_we", 64'(repair_we_o), 64'd1);
        check("sb_repair_busy", 64'(busy_o), 64'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    reset_n = 1'b0;
    alloc_vld_i = 1'b0;
    retire_vld_i = 1'b0;
    mispredict_i = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic alloc(input logic [3:0] p, input logic [63:0] tos,
                       input bit exp_ack, input logic [3:0] exp_tag);
    alloc_vld_i = 1'b1;
    alloc_ptr_i = p;
    alloc_tos_i = tos;
    @(negedge clock);
    check("alloc_ack", 64'(alloc_ack_o), 64'(exp_ack));
    if (exp_ack) check("alloc_tag", 64'(alloc_tag_o), 64'(exp_tag));
    @(posedge clock);
    #1 alloc_vld_i = 1'b0;
  endtask

  task automatic mispredict(input logic [3:0] t, input bit ret, input bit exp_valid,
                            input logic [3:0] exp_ptr, input logic [63:0] exp_data);
    exp_repair_t e;
    mispredict_i = 1'b1;
    mispredict_tag_i = t;
    retire_vld_i = ret;
    if (exp_valid) begin
      e.ptr = exp_ptr;
      e.data = exp_data;
      sb_q.push_back(e);
    end
    @(posedge clock);
    #1;
    mispredict_i = 1'b0;
    retire_vld_i = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // 1: fill the queue
    do_reset();
    @(negedge clock);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_full", 64'(full_o), 64'd0);
    check("rst_repair_vld", 64'(repair_vld_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_tag", 64'(alloc_tag_o), 64'd0);
    @(posedge clock);
    #1;
    for (int i = 0; i < 16; i++) begin
      alloc(4'(i), 64'h1000 + 64'(i), 1'b1, 4'(i));
    end
    @(negedge clock);
    check("fill_full", 64'(full_o), 64'd1);
    check("fill_count", 64'(count_o), 64'd16);
    @(posedge clock);
    #1;
    alloc(4'd0, 64'h0, 1'b0, 4'd0);
    @(negedge clock);
    check("over_count", 64'(count_o), 64'd16);
    @(posedge clock);
    #1;

    // 2: retire + alloc at full; the alloc is refused, the retire frees head
    retire_vld_i = 1'b1;
    alloc(4'd7, 64'h2000, 1'b0, 4'd0);
    retire_vld_i = 1'b0;
    @(negedge clock);
    check("ret_count", 64'(count_o), 64'd15);
    check("ret_full", 64'(full_o), 64'd0);
    @(posedge clock);
    #1;
    alloc(4'd7, 64'h2000, 1'b1, 4'd0);
    @(negedge clock);
    check("wrap_count", 64'(count_o), 64'd16);
    check("wrap_full", 64'(full_o), 64'd1);
    @(posedge clock);
    #1;

    // 3: single mispredict and one-cycle repair
    do_reset();
    for (int i = 0; i < 6; i++) alloc(4'(i), 64'h1000 + 64'(i), 1'b1, 4'(i));
    mispredict(4'd3, 1'b0, 1'b1, 4'd3, 64'h1003);
    check("mp3_vld", 64'(repair_vld_o), 64'd1);
    check("mp3_count", 64'(count_o), 64'd3);
    alloc(4'd9, 64'h9999, 1'b0, 4'd0);
    check("mp3_busy_clr", 64'(busy_o), 64'd0);
    check("mp3_vld_clr", 64'(repair_vld_o), 64'd0);
    alloc(4'd3, 64'h1003, 1'b1, 4'd3);
    check("mp3_count2", 64'(count_o), 64'd4);
    check("mp3_err", 64'(err_o), 64'd0);

    // 4: newer mispredict during REPAIR wins
    do_reset();
    for (int i = 0; i < 6; i++) alloc(4'(i), 64'h1000 + 64'(i), 1'b1, 4'(i));
    mispredict(4'd4, 1'b0, 1'b1, 4'd4, 64'h1004);
    mispredict(4'd2, 1'b0, 1'b1, 4'd2, 64'h1002);
    check("mp2_busy", 64'(busy_o), 64'd1);
    check("mp2_count", 64'(count_o), 64'd2);
    check("mp2_tag", 64'(alloc_tag_o), 64'd2);
    idle_cycle();
    check("mp2_busy_clr", 64'(busy_o), 64'd0);

    // mispredict of head with retire: queue empties
    do_reset();
    for (int i = 0; i < 3; i++) alloc(4'(i), 64'h1000 + 64'(i), 1'b1, 4'(i));
    mispredict(4'd0, 1'b1, 1'b1, 4'd0, 64'h1000);
    check("mph_count", 64'(count_o), 64'd0);
    idle_cycle();

    // 5: out-of-window and empty-queue mispredicts
    do_reset();
    for (int i = 0; i < 3; i++) alloc(4'(i), 64'h1000 + 64'(i), 1'b1, 4'(i));
    mispredict(4'd3, 1'b0, 1'b0, 4'd0, 64'h0);
    check("oow_err", 64'(err_o), 64'd1);
    check("oow_vld", 64'(repair_vld_o), 64'd0);
    check("oow_count", 64'(count_o), 64'd3);
    idle_cycle();
    check("oow_sticky", 64'(err_o), 64'd1);
    do_reset();
    check("err_rst", 64'(err_o), 64'd0);
    retire_vld_i = 1'b1;
    idle_cycle();
    retire_vld_i = 1'b0;
    check("ret_empty_count", 64'(count_o), 64'd0);
    mispredict(4'd0, 1'b0, 1'b0, 4'd0, 64'h0);
    check("empty_err", 64'(err_o), 64'd1);
    check("empty_vld", 64'(repair_vld_o), 64'd0);

    // 6: reset during REPAIR
    do_reset();
    for (int i = 0; i < 4; i++) alloc(4'(i), 64'h1000 + 64'(i), 1'b1, 4'(i));
    mispredict(4'd1, 1'b0, 1'b1, 4'd1, 64'h1001);
    check("rr_busy", 64'(busy_o), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rr_vld", 64'(repair_vld_o), 64'd0);
    check("rr_we", 64'(repair_we_o), 64'd0);
    check("rr_busy0", 64'(busy_o), 64'd0);
    check("rr_count", 64'(count_o), 64'd0);
    check("rr_data", repair_data_o, 64'd0);
    sb_q.delete();
    @(posedge clock);
    #1 reset_n = 1'b1;
    alloc(4'd5, 64'h5555, 1'b1, 4'd0);
    check("rr_count1", 64'(count_o), 64'd1);

    idle_cycle();
    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
